// File: rtl/paper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : paper_pkg
// Purpose  : Shared definitions for the paper-computer sequencer: default
//            widths, opcode values and the sequencer state encoding.
// Ports    : none (package)
// Config   : none here; SINGLE_STEP_EN is consumed by paper_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package paper_pkg;

  localparam int PC_W_DEFAULT = 2;
  localparam int OP_W_DEFAULT = 2;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_JNO  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_WAIT   = ST_WAIT,
    S_EXEC   = ST_EXEC,
    S_HALTED = ST_HALTED
  } state_t;

endpackage
`default_nettype wire

// File: rtl/paper_decode.sv
`default_nettype none
// ============================================================================
// Module   : paper_decode
// Purpose  : Combinational decode of one instruction word plus the status
//            flag into the actions the sequencer takes when it retires it.
// Ports    : instr   in   {opcode, target} instruction register contents
//            status  in   status flag from the increment stage
//            pc      in   address of the instruction being decoded
//            inc     out  instruction is INC
//            halt    out  instruction is HALT
//            next_pc out  address of the following instruction (the JNO
//                         taken/not-taken decision is folded in here)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module paper_decode
  import paper_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT,
  parameter int OP_W = OP_W_DEFAULT
) (
  input  logic [OP_W+PC_W-1:0] instr,
  input  logic                 status,
  input  logic [PC_W-1:0]      pc,
  output logic                 inc,
  output logic                 halt,
  output logic [PC_W-1:0]      next_pc
);

  logic [OP_W-1:0] opcode;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] seq_pc;

  assign opcode = instr[OP_W+PC_W-1:PC_W];
  assign target = instr[PC_W-1:0];
  // Natural PC_W-bit overflow gives the required wrap to address 0.
  assign seq_pc = pc + PC_W'(1);

  always_comb begin
    inc     = 1'b0;
    halt    = 1'b0;
    next_pc = seq_pc;
    case (opcode)
      OP_W'(OP_INC):  inc = 1'b1;
      OP_W'(OP_JNO):  if (!status) next_pc = target;
      OP_W'(OP_HALT): halt = 1'b1;
      OP_W'(OP_NOP):  next_pc = seq_pc;
      default:        next_pc = seq_pc;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/paper_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : paper_sequencer
// Purpose  : Fetch/decode/issue FSM for the paper computer. Owns the PC,
//            reads program memory, pulses the increment stage and resolves
//            JNO against the returned status flag. 3 cycles per instruction.
// Ports    : clock      in   system clock (rising edge)
//            reset_n    in   asynchronous active-low reset
//            start      in   leave IDLE/HALTED and run from address 0
//            imem_addr  out  program memory read address
//            imem_data  in   instruction word, valid one cycle after address
//            status     in   status flag from the increment stage
//            inc_strobe out  one-cycle increment pulse
//            pc         out  address of the executing instruction
//            busy       out  high in FETCH/WAIT/EXEC
//            halted     out  high in HALTED
//            step       in   (SINGLE_STEP_EN only) retire the EXEC instruction
// Config   : SINGLE_STEP_EN - adds the step port; EXEC holds until step=1.
// Revision : 1.0 - initial release
// ============================================================================
module paper_sequencer
  import paper_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT,
  parameter int OP_W = OP_W_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [OP_W+PC_W-1:0] imem_data,
  input  logic                 status,
  output logic                 inc_strobe,
  output logic [PC_W-1:0]      pc,
  output logic                 busy,
  output logic                 halted
`ifdef SINGLE_STEP_EN
  ,
  input  logic                 step
`endif
);

  state_t                state;
  logic [OP_W+PC_W-1:0]  instr;
  logic                  dec_inc;
  logic                  dec_halt;
  logic [PC_W-1:0]       dec_next_pc;
  logic                  retire;

`ifdef SINGLE_STEP_EN
  assign retire = step;
`else
  assign retire = 1'b1;
`endif

  paper_decode #(
    .PC_W (PC_W),
    .OP_W (OP_W)
  ) u_decode (
    .instr   (instr),
    .status  (status),
    .pc      (pc),
    .inc     (dec_inc),
    .halt    (dec_halt),
    .next_pc (dec_next_pc)
  );

  // Combinational so an asynchronous reset in EXEC drops the pulse at once.
  assign inc_strobe = (state == S_EXEC) && retire && dec_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      imem_addr <= '0;
      instr     <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state     <= S_FETCH;
            pc        <= '0;
            imem_addr <= '0;
            busy      <= 1'b1;
            halted    <= 1'b0;
          end
        end
        S_FETCH: begin
          // Address is presented during FETCH so a registered memory has
          // the word ready for the WAIT cycle.
          imem_addr <= pc;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          instr <= imem_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (retire) begin
            if (dec_halt) begin
              state  <= S_HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              pc        <= dec_next_pc;
              imem_addr <= dec_next_pc;
              state     <= S_FETCH;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_paper_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_paper_sequencer
// Purpose  : Self-checking bench for paper_sequencer: table of short
//            programs, directed multi-cycle sequences and a randomized run,
//            all compared against an instruction-level reference model.
// Config   : SINGLE_STEP_EN - also exercises the step port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paper_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       status;
  logic       inc_strobe;
  logic       busy;
  logic       halted;
  logic [1:0] imem_addr;
  logic [1:0] pc;
  logic [3:0] imem_data;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif
  logic       step_drv;
  logic [15:0] progw;   // {w3, w2, w1, w0}, each word {op[1:0], target[1:0]}

  int total = 0;
  int bad   = 0;

  // Reference model: instruction-level view, cycles left until retire.
  int m_pc;
  int m_left;
  bit m_busy;
  bit m_halted;

  always #5 clock = ~clock;

  // Registered program memory: word for imem_addr appears one cycle later.
  always @(posedge clock) imem_data <= progw[{imem_addr, 2'b00} +: 4];

  paper_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .status     (status),
    .inc_strobe (inc_strobe),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted)
`ifdef SINGLE_STEP_EN
    ,
    .step       (step)
`endif
  );

  typedef struct {
    logic [15:0] prog;
    logic        sts;
    int          incs;
    int          first;
    int          gap;
    int          hlt;
    int          fpc;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [3:0] word_at(input int a);
    logic [15:0] w;
    w = progw;
    return w[a*4 +: 4];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_halted = 0; m_pc = 0; m_left = 0;
  endtask

  task automatic model_step(input logic st, input logic sts, input logic stp);
    logic [3:0] w;
    if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_halted = 0; m_pc = 0; m_left = 3;
      end
    end else if (m_left > 1) begin
      m_left--;
    end else if (stp) begin
      w = word_at(m_pc);
      if (w[3:2] == 2'b10) begin
        m_busy = 0; m_halted = 1;
      end else begin
        if (w[3:2] == 2'b01 && !sts) m_pc = int'(w[1:0]);
        else m_pc = (m_pc + 1) % 4;
        m_left = 3;
      end
    end
  endtask

  // Called at a negedge: drive inputs, check outputs against the model,
  // advance the model over the coming posedge, return at the next negedge.
  task automatic tick(input logic st, input logic sts, output logic inc_seen);
    logic [3:0] w;
    logic       exp_inc;
    start  = st;
    status = sts;
`ifdef SINGLE_STEP_EN
    step = step_drv;
`endif
    #1;
    w = word_at(m_pc);
    exp_inc = m_busy && (m_left == 1) && step_drv && (w[3:2] == 2'b00);
    chk("pc", int'(pc), m_pc);
    chk("busy", int'(busy), int'(m_busy));
    chk("halted", int'(halted), int'(m_halted));
    chk("inc_strobe", int'(inc_strobe), int'(exp_inc));
    if (m_busy && m_left <= 2) chk("imem_addr", int'(imem_addr), m_pc);
    inc_seen = inc_strobe;
    model_step(st, sts, step_drv);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    status  = 1'b0;
    #1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_inc", int'(inc_strobe), 0);
    chk("rst_addr", int'(imem_addr), 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Start pulse then n further cycles; gather inc pulse statistics.
  task automatic run(input logic [15:0] p, input logic sts, input int n,
                     output int incs, output int first, output int gap);
    logic seen;
    int   last;
    progw = p;
    incs = 0; first = 0; gap = 0; last = 0;
    for (int i = 0; i <= n; i++) begin
      tick(i == 0, sts, seen);
      if (seen) begin
        if (incs > 0) gap = i - last;
        else first = i;
        last = i;
        incs++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   incs, first, gap, cnt;
    int   exp_pcs[5];

    reset_n  = 1'b0;
    start    = 1'b0;
    status   = 1'b0;
    step_drv = 1'b1;
    progw    = 16'hCCCC;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    model_reset();
    @(negedge clock);
    do_reset();

    // prog, status, incs, first inc time, gap, halted, final pc
    vecs[0] = '{16'hC800, 1'b0, 2, 3, 3, 1, 2};  // INC,INC,HALT,NOP
    vecs[1] = '{16'h8CCC, 1'b1, 0, 0, 0, 1, 3};  // NOP,NOP,NOP,HALT
    vecs[2] = '{16'h8070, 1'b0, 1, 3, 0, 1, 3};  // INC,JNO->3,INC,HALT
    vecs[3] = '{16'h8070, 1'b1, 2, 3, 6, 1, 3};
    vecs[4] = '{16'h8086, 1'b0, 1, 6, 0, 1, 3};  // JNO->2,HALT,INC,HALT
    vecs[5] = '{16'h8086, 1'b1, 0, 0, 0, 1, 1};
    vecs[6] = '{16'hCCC8, 1'b0, 0, 0, 0, 1, 0};  // HALT first
    vecs[7] = '{16'hCCCC, 1'b0, 0, 0, 0, 0, 2};  // endless NOPs, wraps

    for (int v = 0; v < 8; v++) begin
      run(vecs[v].prog, vecs[v].sts, 30, incs, first, gap);
      chk("tbl_incs", incs, vecs[v].incs);
      chk("tbl_first", first, vecs[v].first);
      chk("tbl_gap", gap, vecs[v].gap);
      chk("tbl_halted", int'(halted), vecs[v].hlt);
      chk("tbl_pc", int'(pc), vecs[v].fpc);
    end
    do_reset();

    // Reset during EXEC of INC drops the pulse, then stays idle.
    progw = 16'hC800;
    tick(1'b1, 1'b0, seen);
    tick(1'b0, 1'b0, seen);
    tick(1'b0, 1'b0, seen);
    chk("exec_inc_pre_reset", int'(inc_strobe), 1);
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, seen);
    chk("idle_busy", int'(busy), 0);
    chk("idle_pc", int'(pc), 0);

    // INC / JNO->0 loop with status 0, then status 1 falls through.
    run(16'h8840, 1'b0, 24, incs, first, gap);
    chk("loop_incs", incs, 4);
    chk("loop_gap", gap, 6);
    for (int i = 0; i < 20 && !halted; i++) tick(1'b0, 1'b1, seen);
    chk("loop_exit_halted", int'(halted), 1);
    chk("loop_exit_pc", int'(pc), 2);
    do_reset();

    // NOP,NOP,NOP,JNO->1 with status 1: pc wraps 3 -> 0.
    progw = 16'h5CCC;
    exp_pcs[0] = 0; exp_pcs[1] = 1; exp_pcs[2] = 2; exp_pcs[3] = 3; exp_pcs[4] = 0;
    cnt = 0;
    for (int i = 0; i < 13; i++) begin
      tick(i == 0, 1'b1, seen);
      if (seen) cnt++;
      if ((i + 1) % 3 == 1) chk("wrap_pc", int'(pc), exp_pcs[(i + 1) / 3]);
    end
    chk("wrap_incs", cnt, 0);
    do_reset();

    // start during WAIT ignored; start while HALTED refetches from 0.
    progw = 16'hCC8C;
    tick(1'b1, 1'b0, seen);
    tick(1'b0, 1'b0, seen);
    tick(1'b1, 1'b0, seen);
    for (int i = 0; i < 20 && !halted; i++) tick(1'b0, 1'b0, seen);
    chk("halt_halted", int'(halted), 1);
    chk("halt_pc", int'(pc), 1);
    tick(1'b1, 1'b0, seen);
    chk("restart_busy", int'(busy), 1);
    chk("restart_halted", int'(halted), 0);
    chk("restart_pc", int'(pc), 0);
    for (int i = 0; i < 20 && !halted; i++) tick(1'b0, 1'b0, seen);
    chk("rehalt_pc", int'(pc), 1);

    // Randomized run against the model.
    for (int c = 0; c < 800; c++) begin
      if (!m_busy && $urandom_range(0, 7) == 0) progw = 16'($urandom);
`ifdef SINGLE_STEP_EN
      step_drv = 1'($urandom_range(0, 1));
`endif
      tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), seen);
    end
    step_drv = 1'b1;

`ifdef SINGLE_STEP_EN
    do_reset();
    progw = 16'hC800;
    step_drv = 1'b0;
    tick(1'b1, 1'b0, seen);
    step_drv = 1'b1;             // step during FETCH has no effect
    tick(1'b0, 1'b0, seen);
    step_drv = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, seen);
      if (seen) cnt++;
    end
    chk("step_hold_incs", cnt, 0);
    chk("step_hold_pc", int'(pc), 0);
    step_drv = 1'b1;
    tick(1'b0, 1'b0, seen);
    chk("step_inc", int'(seen), 1);
    chk("step_pc", int'(pc), 1);
    for (int i = 0; i < 20 && !halted; i++) tick(1'b0, 1'b0, seen);
    chk("step_halted", int'(halted), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
